// File: rtl/pll_phase_ctrl.sv
// ECP5 EHXPLLL bring-up and phase-step sequencer.
// Resets the PLL until lock, then turns step requests into PHASESTEP pulses.
module pll_phase_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 8,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int SETUP_CYCLES = 2,
  parameter int STEP_CYCLES  = 4,
  parameter int HOLD_CYCLES  = 4,
  parameter int PHASE_STEPS  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic       req_dir,
  input  logic [3:0] req_count,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic [1:0] pll_phasesel,
  output logic       pll_phasedir,
  output logic       pll_phasestep,
  output logic       locked,
  output logic       busy,
  output logic [6:0] phase_pos,
  output logic [3:0] retries
);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD
  } state_t;

  localparam logic [15:0] RST_LAST   = 16'(RST_CYCLES - 1);
  localparam logic [15:0] STAB_LAST  = 16'(LOCK_STABLE - 1);
  localparam logic [15:0] TMO_LAST   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] STEP_LAST  = 16'(STEP_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 1);
  localparam logic [6:0]  POS_LAST   = 7'(PHASE_STEPS - 1);

  state_t      state_q, state_d;
  logic        lock_meta_q, lock_meta_d;
  logic        lock_sync_q, lock_sync_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] stab_q, stab_d;
  logic [3:0]  rem_q, rem_d;
  logic [1:0]  sel_q, sel_d;
  logic        dir_q, dir_d;
  logic [6:0]  pos_q, pos_d;
  logic [3:0]  retries_q, retries_d;
  logic        run_st;

  assign run_st = (state_q == S_SETUP) || (state_q == S_PULSE) ||
                  (state_q == S_HOLD);

  assign pll_rst       = (state_q == S_RESET);
  assign req_ready     = (state_q == S_IDLE) && lock_sync_q;
  assign busy          = run_st;
  assign locked        = (state_q == S_IDLE) || run_st;
  assign pll_phasestep = (state_q == S_PULSE);
  assign pll_phasesel  = sel_q;
  assign pll_phasedir  = dir_q;
  assign phase_pos     = pos_q;
  assign retries       = retries_q;

  // Next-state: bring-up sequencing, step timing and phase bookkeeping.
  always_comb begin
    state_d     = state_q;
    lock_meta_d = pll_lock;
    lock_sync_d = lock_meta_q;
    cnt_d       = cnt_q;
    stab_d      = stab_q;
    rem_d       = rem_q;
    sel_d       = sel_q;
    dir_d       = dir_q;
    pos_d       = pos_q;
    retries_d   = retries_q;

    unique case (state_q)
      S_RESET: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
          stab_d  = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT_LOCK: begin
        stab_d = lock_sync_q ? stab_q + 16'd1 : '0;
        cnt_d  = cnt_q + 16'd1;
        if (lock_sync_q && (stab_q == STAB_LAST)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_RESET;
          cnt_d   = '0;
          if (retries_q != 4'hf) begin
            retries_d = retries_q + 4'd1;
          end
        end
      end
      S_IDLE: begin
        if (req_valid && req_ready) begin
          sel_d = req_sel;
          dir_d = req_dir;
          rem_d = req_count;
          cnt_d = '0;
          if (req_count != 4'd0) begin
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_PULSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_PULSE: begin
        if (cnt_q == STEP_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          rem_d   = rem_q - 4'd1;
          if (sel_q == 2'd0) begin
            if (dir_q) begin
              pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 7'd1;
            end else begin
              pos_d = (pos_q == 7'd0) ? POS_LAST : pos_q - 7'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = (rem_q != 4'd0) ? S_SETUP : S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_RESET;
        cnt_d   = '0;
      end
    endcase

    // Losing lock after bring-up restarts the PLL; its phase returns to 0.
    if (!lock_sync_q && ((state_q == S_IDLE) || run_st)) begin
      state_d = S_RESET;
      cnt_d   = '0;
      rem_d   = '0;
      pos_d   = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RESET;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      cnt_q       <= '0;
      stab_q      <= '0;
      rem_q       <= '0;
      sel_q       <= '0;
      dir_q       <= 1'b0;
      pos_q       <= '0;
      retries_q   <= '0;
    end else begin
      state_q     <= state_d;
      lock_meta_q <= lock_meta_d;
      lock_sync_q <= lock_sync_d;
      cnt_q       <= cnt_d;
      stab_q      <= stab_d;
      rem_q       <= rem_d;
      sel_q       <= sel_d;
      dir_q       <= dir_d;
      pos_q       <= pos_d;
      retries_q   <= retries_d;
    end
  end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Bench for pll_phase_ctrl: bring-up, stepping, wrap, lock loss, timeout.
// Expected values come from modular phase arithmetic and step timing.
module tb_pll_phase_ctrl;

  localparam int TMO    = 100;
  localparam int RSTC   = 16;
  localparam int PS     = 16;
  localparam int STEP_T = 2 + 4 + 4;
  localparam int LOOP_T = RSTC + TMO;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_sel;
  logic       req_dir;
  logic [3:0] req_count;
  logic       pll_lock;
  logic       pll_rst;
  logic [1:0] pll_phasesel;
  logic       pll_phasedir;
  logic       pll_phasestep;
  logic       locked;
  logic       busy;
  logic [6:0] phase_pos;
  logic [3:0] retries;

  int checks = 0;
  int errors = 0;
  int exp_pos = 0;
  int exp_retries = 0;

  always #5 clk = ~clk;

  pll_phase_ctrl #(.LOCK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_dir(req_dir), .req_count(req_count),
    .pll_lock(pll_lock), .pll_rst(pll_rst),
    .pll_phasesel(pll_phasesel), .pll_phasedir(pll_phasedir),
    .pll_phasestep(pll_phasestep),
    .locked(locked), .busy(busy),
    .phase_pos(phase_pos), .retries(retries)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Phase position after n steps on output sel in direction dir.
  function automatic int model_pos(int pos, int sel, int dir, int n);
    if (sel != 0) return pos;
    if (dir != 0) return (pos + n) % PS;
    return (pos + PS * 16 - n) % PS;
  endfunction

  // Issue one request and record what the PLL pins do until ready returns.
  // t counts edges after the accepting edge; lat is the first t with ready.
  task automatic run_req(input logic [1:0] s, input logic d,
                         input logic [3:0] n, output int lat,
                         output int npulse, output int tbad);
    int  w;
    logic prev;
    logic [6:0] ppos;
    lat = -1; npulse = 0; tbad = 0; w = 0; prev = 1'b0;
    for (int i = 0; i < 300 && !req_ready; i++) tick();
    if (!req_ready) return;
    ppos = phase_pos;
    req_valid = 1'b1; req_sel = s; req_dir = d; req_count = n;
    tick();
    req_valid = 1'b0;
    req_sel = 2'($urandom); req_dir = 1'($urandom);
    req_count = 4'($urandom);
    for (int t = 0; t < 400; t++) begin
      if (pll_phasestep) begin
        if (!prev) begin
          npulse++;
          if (t % STEP_T != 2) tbad++;
        end
        w++;
      end else if (prev) begin
        if (w != 4) tbad++;
        w = 0;
      end
      if (pll_phasestep && !busy) tbad++;
      if (busy && (pll_phasesel !== s || pll_phasedir !== d)) tbad++;
      if (phase_pos !== ppos && (t % STEP_T) != 6) tbad++;
      ppos = phase_pos;
      prev = pll_phasestep;
      if (req_ready) begin
        lat = t;
        if (prev) tbad++;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_lock = 1'b0; req_valid = 1'b0;
    req_sel = '0; req_dir = 1'b0; req_count = '0;
    repeat (3) tick();
    checks++;
    if (pll_rst !== 1'b1) begin
      errors++; $display("FAIL rst_pll_rst: got %0b want 1", pll_rst);
    end
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags: ready=%0b busy=%0b locked=%0b want 0 0 0",
               req_ready, busy, locked);
    end
    checks++;
    if (pll_phasestep !== 1'b0 || pll_phasesel !== 2'd0 ||
        pll_phasedir !== 1'b0) begin
      errors++;
      $display("FAIL rst_pins: step=%0b sel=%0d dir=%0b want 0 0 0",
               pll_phasestep, pll_phasesel, pll_phasedir);
    end
    checks++;
    if (phase_pos !== 7'd0 || retries !== 4'd0) begin
      errors++;
      $display("FAIL rst_counts: pos=%0d retries=%0d want 0 0",
               phase_pos, retries);
    end
  endtask

  task automatic test_bringup();
    int frst = -1;
    int flk  = -1;
    rst = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (frst < 0 && !pll_rst) frst = k;
      if (flk < 0 && locked) flk = k;
      if (k == 40) pll_lock = 1'b1;
    end
    checks++;
    if (frst !== RSTC) begin
      errors++; $display("FAIL bringup_rst_fall: got %0d want %0d", frst, RSTC);
    end
    checks++;
    if (flk < 50 || flk > 52) begin
      errors++; $display("FAIL bringup_locked: got %0d want 50..52", flk);
    end
    checks++;
    if (retries !== 4'(exp_retries) || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bringup_idle: retries=%0d ready=%0b want %0d 1",
               retries, req_ready, exp_retries);
    end
  endtask

  task automatic test_stepping();
    int lat, np, tb;
    run_req(2'd0, 1'b1, 4'd3, lat, np, tb);
    exp_pos = model_pos(exp_pos, 0, 1, 3);
    checks++;
    if (lat != 3 * STEP_T) begin
      errors++; $display("FAIL step3_latency: got %0d want %0d", lat, 3 * STEP_T);
    end
    checks++;
    if (np != 3) begin
      errors++; $display("FAIL step3_pulses: got %0d want 3", np);
    end
    checks++;
    if (tb != 0) begin
      errors++; $display("FAIL step3_timing: got %0d bad cycles want 0", tb);
    end
    checks++;
    if (phase_pos !== 7'(exp_pos)) begin
      errors++; $display("FAIL step3_pos: got %0d want %0d", phase_pos, exp_pos);
    end
  endtask

  task automatic test_wrap();
    int lat, np, tb;
    int dirs[3] = '{0, 0, 1};
    int cnts[3] = '{3, 1, 2};
    for (int i = 0; i < 3; i++) begin
      run_req(2'd0, 1'(dirs[i]), 4'(cnts[i]), lat, np, tb);
      exp_pos = model_pos(exp_pos, 0, dirs[i], cnts[i]);
      checks++;
      if (phase_pos !== 7'(exp_pos) || np != cnts[i] || tb != 0) begin
        errors++;
        $display("FAIL wrap_%0d: pos=%0d pulses=%0d bad=%0d want %0d %0d 0",
                 i, phase_pos, np, tb, exp_pos, cnts[i]);
      end
    end
  endtask

  task automatic test_other_sel();
    int lat, np, tb;
    run_req(2'd2, 1'b1, 4'd5, lat, np, tb);
    checks++;
    if (np != 5 || lat != 5 * STEP_T || tb != 0) begin
      errors++;
      $display("FAIL sel2: pulses=%0d lat=%0d bad=%0d want 5 %0d 0",
               np, lat, tb, 5 * STEP_T);
    end
    checks++;
    if (phase_pos !== 7'(exp_pos)) begin
      errors++; $display("FAIL sel2_pos: got %0d want %0d", phase_pos, exp_pos);
    end
    run_req(2'd1, 1'b0, 4'd0, lat, np, tb);
    checks++;
    if (np != 0 || lat != 0) begin
      errors++;
      $display("FAIL count0: pulses=%0d lat=%0d want 0 0", np, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat, np, tb, s, d, n;
    for (int i = 0; i < 12; i++) begin
      s = $urandom_range(0, 3);
      d = $urandom_range(0, 1);
      n = $urandom_range(0, 6);
      run_req(2'(s), 1'(d), 4'(n), lat, np, tb);
      exp_pos = model_pos(exp_pos, s, d, n);
      checks++;
      if (lat != n * STEP_T || np != n || tb != 0) begin
        errors++;
        $display("FAIL b2b_%0d: lat=%0d pulses=%0d bad=%0d want %0d %0d 0",
                 i, lat, np, tb, n * STEP_T, n);
      end
      checks++;
      if (phase_pos !== 7'(exp_pos)) begin
        errors++;
        $display("FAIL b2b_pos_%0d: got %0d want %0d", i, phase_pos, exp_pos);
      end
    end
  endtask

  task automatic test_lock_loss();
    int fall_k = -1;
    int rst_hi = 0;
    int rdy_bad = 0;
    int pos_f = -1;
    int lk_f = -1;
    logic relocked = 1'b0;
    for (int i = 0; i < 300 && !req_ready; i++) tick();
    req_valid = 1'b1; req_sel = 2'd0; req_dir = 1'b1; req_count = 4'd3;
    tick();
    req_valid = 1'b0;
    repeat (13) tick();
    checks++;
    if (pll_phasestep !== 1'b1) begin
      errors++; $display("FAIL loss_pulse2: got %0b want 1", pll_phasestep);
    end
    pll_lock = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (fall_k < 0 && !pll_phasestep) begin
        fall_k = k; pos_f = phase_pos; lk_f = locked;
      end
      if (pll_rst) rst_hi++;
      if (req_ready && !locked) rdy_bad++;
      if (k == 6) pll_lock = 1'b1;
      if (locked && k > 6) begin
        relocked = 1'b1;
        break;
      end
    end
    exp_pos = 0;
    checks++;
    if (fall_k < 1 || fall_k > 3) begin
      errors++; $display("FAIL loss_step_fall: got %0d want 1..3", fall_k);
    end
    checks++;
    if (pos_f != 0 || lk_f != 0) begin
      errors++;
      $display("FAIL loss_state: pos=%0d locked=%0d want 0 0", pos_f, lk_f);
    end
    checks++;
    if (rst_hi != RSTC || rdy_bad != 0) begin
      errors++;
      $display("FAIL loss_rst: rst_cycles=%0d early_ready=%0d want %0d 0",
               rst_hi, rdy_bad, RSTC);
    end
    checks++;
    if (!relocked || retries !== 4'(exp_retries) || phase_pos !== 7'd0) begin
      errors++;
      $display("FAIL loss_relock: relocked=%0b retries=%0d pos=%0d want 1 %0d 0",
               relocked, retries, phase_pos, exp_retries);
    end
  endtask

  task automatic test_timeout();
    int rst_bad = 0;
    int ret_bad = 0;
    int er;
    logic relocked = 1'b0;
    rst = 1'b1; pll_lock = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 1; k <= 17 * LOOP_T + 20; k++) begin
      tick();
      er = (k / LOOP_T > 15) ? 15 : k / LOOP_T;
      if (pll_rst !== 1'((k % LOOP_T) < RSTC)) rst_bad++;
      if (retries !== 4'(er)) ret_bad++;
    end
    exp_retries = 15;
    checks++;
    if (rst_bad != 0) begin
      errors++; $display("FAIL timeout_rst: got %0d bad cycles want 0", rst_bad);
    end
    checks++;
    if (ret_bad != 0) begin
      errors++; $display("FAIL timeout_retries: got %0d bad cycles want 0", ret_bad);
    end
    pll_lock = 1'b1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (locked) begin
        relocked = 1'b1;
        break;
      end
    end
    checks++;
    if (!relocked || retries !== 4'(exp_retries)) begin
      errors++;
      $display("FAIL timeout_relock: relocked=%0b retries=%0d want 1 %0d",
               relocked, retries, exp_retries);
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_stepping();
    test_wrap();
    test_other_sel();
    test_back_to_back();
    test_lock_loss();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_phase_ctrl.md
# pll_phase_ctrl

Sequencer for the ECP5 EHXPLLL that clocks the DDR3 controller. It runs the PLL reset and lock bring-up, and retries automatically on lock timeout. It also accepts phase-shift requests from the read/write leveling logic and converts them into correctly timed PHASESEL/PHASEDIR/PHASESTEP sequences. It keeps a modular record of the CLKOP phase position so the leveling logic can report and restore it.

## Interface

Parameters:
- RST_CYCLES, 16: cycles pll_rst stays high per reset attempt.
- LOCK_STABLE, 8: consecutive synchronized-lock cycles required before leaving WAIT_LOCK.
- LOCK_TIMEOUT, 65535: cycles in WAIT_LOCK before a retry; 16-bit counter.
- SETUP_CYCLES, 2: cycles that PHASESEL/PHASEDIR are stable before the step pulse.
- STEP_CYCLES, 4: width of the pll_phasestep high pulse.
- HOLD_CYCLES, 4: cycles that PHASESEL/PHASEDIR are held after the pulse.
- PHASE_STEPS, 16: phase positions per VCO cycle; phase_pos wraps modulo this value.

Ports:
- clk, in, 1: single system clock.
- rst, in, 1: asynchronous, active-high reset.
- req_valid, in, 1: phase-step request is valid.
- req_ready, out, 1: controller can accept a request.
- req_sel, in, 2: PLL output to shift; 0 selects CLKOP.
- req_dir, in, 1: 1 advances the phase, 0 retards it.
- req_count, in, 4: number of steps, 0 to 15.
- pll_lock, in, 1: raw PLL LOCK output; asynchronous.
- pll_rst, out, 1: PLL RST.
- pll_phasesel, out, 2: PLL PHASESEL1/PHASESEL0.
- pll_phasedir, out, 1: PLL PHASEDIR.
- pll_phasestep, out, 1: PLL PHASESTEP.
- locked, out, 1: PLL is up and stable.
- busy, out, 1: a step sequence is in progress.
- phase_pos, out, 7: CLKOP phase position, 0 to PHASE_STEPS-1.
- retries, out, 4: count of lock timeouts; saturates at 15.

## Operation

- pll_lock passes through a 2-flop synchronizer. Every use of lock below refers to the synchronized value.
- State RESET:
  - pll_rst=1 and a counter runs for RST_CYCLES cycles.
  - Then go to WAIT_LOCK.
- State WAIT_LOCK:
  - pll_rst=0.
  - A stable counter increments while lock=1 and clears when lock=0.
  - When the stable counter reaches LOCK_STABLE, go to IDLE and set locked=1.
  - If the timeout counter reaches LOCK_TIMEOUT first, go to RESET and increment retries (saturating).
- State IDLE:
  - req_ready=1 only in this state.
  - A handshake (req_valid & req_ready) latches sel, dir and count.
  - If count==0, stay in IDLE; no pulse is produced.
  - Otherwise go to SETUP.
- State SETUP: drive pll_phasesel and pll_phasedir for SETUP_CYCLES cycles, then go to PULSE.
- State PULSE:
  - pll_phasestep=1 for STEP_CYCLES cycles.
  - On the last cycle, decrement the remaining count.
  - If sel==0, update phase_pos: +1 if dir=1, -1 if dir=0, modulo PHASE_STEPS (15+1 wraps to 0; 0-1 wraps to 15).
- State HOLD:
  - Hold pll_phasesel and pll_phasedir for HOLD_CYCLES cycles.
  - If the remaining count is nonzero, go to SETUP; otherwise go to IDLE.
- busy=1 in SETUP, PULSE and HOLD.
- Lock loss: lock=0 in IDLE, SETUP, PULSE or HOLD causes a transition to RESET on the next edge. It has these effects:
  - the in-flight request is aborted;
  - pll_phasestep drops immediately;
  - locked=0;
  - phase_pos=0, because a PLL reset restores the programmed phase.
  - A lock loss is not counted in retries.
- While the state is not IDLE, pll_phasesel and pll_phasedir hold their last driven values. They are 0 after reset.

## Timing

- Reset values: pll_rst=1, state=RESET, req_ready=0, locked=0, busy=0, pll_phasestep=0, pll_phasesel=0, pll_phasedir=0, phase_pos=0, retries=0.
- Bring-up, measured from rst deassertion:
  - pll_rst falls after RST_CYCLES cycles.
  - locked rises no earlier than 2 synchronizer cycles plus LOCK_STABLE cycles after raw lock rises.
- Handshake:
  - req_ready falls on the cycle after acceptance.
  - req_* is sampled only on the accept cycle.
  - With count==0, req_ready is 1 again on the following cycle.
- Per step: SETUP_CYCLES+STEP_CYCLES+HOLD_CYCLES cycles (10 with defaults).
- An N-step request returns to IDLE N×10 cycles after acceptance, and req_ready rises on that cycle.
- phase_pos updates on the edge that ends the pulse. It is visible on the cycle after pll_phasestep falls.
- pll_phasestep is never high outside PULSE. Each pulse is exactly STEP_CYCLES wide unless it is aborted by lock loss.

## Test plan

- Bring-up: release rst, raise pll_lock at cycle 40 → pll_rst falls at cycle 16; locked=1 at cycle 50 or later; retries=0.
- Timeout: hold pll_lock=0 with LOCK_TIMEOUT=100 → pll_rst re-pulses for 16 cycles; retries increments on each cycle of the loop; raising lock afterwards reaches locked=1.
- Stepping: sel=0, dir=1, count=3 → exactly three 4-cycle pulses with 2-cycle setup and 4-cycle hold; phasedir=1 throughout; phase_pos 0→3; req_ready returns 30 cycles after acceptance.
- Wrap: from phase_pos=0, sel=0, dir=0, count=1 → phase_pos=15. Then dir=1, count=2 → phase_pos=1.
- Other output and count 0: sel=2, count=5 → five pulses with phasesel=2 and phase_pos unchanged. A count=0 request → no pulse and req_ready is back after 1 cycle.
- Lock loss: drop pll_lock during the second pulse → pll_phasestep falls within 3 cycles; locked=0; phase_pos=0; pll_rst pulses; req_ready stays 0 until re-lock; retries unchanged.
